// File: rtl/test_vector_sequencer_if.sv
// Test vector sequencer bus: vector load port, run control, DUT drive/sense
// and the result valid/ready stream. With SEQ_COMPARE_EN defined the bus also
// carries the expected-response load data and the mismatch counter.
// master: the sequencer. slave: the environment that loads vectors, hosts the
// DUT and consumes results.
interface test_vector_sequencer_if #(
  parameter int INPUT_WIDTH     = 2,
  parameter int OUTPUT_WIDTH    = 1,
  parameter int NUMBER_OF_TESTS = 4
);
  localparam int ADDR_WIDTH = (NUMBER_OF_TESTS > 1) ? $clog2(NUMBER_OF_TESTS) : 1;

  logic                    load_en;
  logic [ADDR_WIDTH-1:0]   load_addr;
  logic [INPUT_WIDTH-1:0]  load_data;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [INPUT_WIDTH-1:0]  dut_in;
  logic [OUTPUT_WIDTH-1:0] dut_out;
  logic                    res_valid;
  logic                    res_ready;
  logic [ADDR_WIDTH-1:0]   res_index;
  logic [OUTPUT_WIDTH-1:0] res_data;
`ifdef SEQ_COMPARE_EN
  logic [OUTPUT_WIDTH-1:0] exp_data;
  logic [ADDR_WIDTH:0]     mismatch_cnt;

  modport master (
    input  load_en, load_addr, load_data, exp_data, start, dut_out, res_ready,
    output busy, done, dut_in, res_valid, res_index, res_data, mismatch_cnt
  );
  modport slave (
    output load_en, load_addr, load_data, exp_data, start, dut_out, res_ready,
    input  busy, done, dut_in, res_valid, res_index, res_data, mismatch_cnt
  );
`else
  modport master (
    input  load_en, load_addr, load_data, start, dut_out, res_ready,
    output busy, done, dut_in, res_valid, res_index, res_data
  );
  modport slave (
    output load_en, load_addr, load_data, start, dut_out, res_ready,
    input  busy, done, dut_in, res_valid, res_index, res_data
  );
`endif
endinterface

// File: rtl/test_vector_sequencer.sv
// Test vector sequencer: stores NUMBER_OF_TESTS stimulus vectors, applies
// them one at a time to an external DUT, waits SETTLE_CYCLES, captures the
// response and hands it out on a valid/ready stream in index order.
// Optional feature macro SEQ_COMPARE_EN: adds an expected-response memory and
// a mismatch counter that is cleared at run start.
module test_vector_sequencer #(
  parameter int INPUT_WIDTH     = 2,
  parameter int OUTPUT_WIDTH    = 1,
  parameter int NUMBER_OF_TESTS = 4,
  parameter int SETTLE_CYCLES   = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  test_vector_sequencer_if.master bus
);
  localparam int ADDR_WIDTH = (NUMBER_OF_TESTS > 1) ? $clog2(NUMBER_OF_TESTS) : 1;
  localparam int CNT_WIDTH  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX  = ADDR_WIDTH'(NUMBER_OF_TESTS - 1);
  localparam logic [CNT_WIDTH-1:0]  SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RESULT, DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   index;
  logic [CNT_WIDTH-1:0]    settle_cnt;
  logic [INPUT_WIDTH-1:0]  dut_in_q;
  logic                    res_valid_q;
  logic [ADDR_WIDTH-1:0]   res_index_q;
  logic [OUTPUT_WIDTH-1:0] res_data_q;
  logic                    busy_q;
  logic                    done_q;

  logic [INPUT_WIDTH-1:0]  mem [NUMBER_OF_TESTS];

  // A write is accepted only while idle; start wins over a simultaneous write.
  logic mem_we;
  assign mem_we = (state == IDLE) && bus.load_en && !bus.start;

  // Result accepted by the consumer on this edge.
  logic handshake;
  assign handshake = (state == RESULT) && res_valid_q && bus.res_ready;

  logic [ADDR_WIDTH-1:0] next_index;
  assign next_index = index + 1'b1;

  // Vector store write port.
  // NOTE: the vector memory has no reset on purpose -- its contents must
  // survive rst_n, and leaving it out keeps it mappable to plain RAM.
  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (mem_we) mem[bus.load_addr] <= bus.load_data;
  end

  // Run sequencer: apply vector, settle, present result, advance or finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      index       <= '0;
      settle_cnt  <= '0;
      dut_in_q    <= '0;
      res_valid_q <= 1'b0;
      res_index_q <= '0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            index      <= '0;
            dut_in_q   <= mem[0];
            busy_q     <= 1'b1;
            settle_cnt <= SETTLE_LAST;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            res_data_q  <= bus.dut_out;
            res_index_q <= index;
            res_valid_q <= 1'b1;
            state       <= RESULT;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        RESULT: begin
          if (handshake) begin
            res_valid_q <= 1'b0;
            if (index == LAST_INDEX) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= DONE;
            end else begin
              index      <= next_index;
              dut_in_q   <= mem[next_index];
              settle_cnt <= SETTLE_LAST;
              state      <= SETTLE;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dut_in    = dut_in_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_index = res_index_q;
  assign bus.res_data  = res_data_q;

`ifdef SEQ_COMPARE_EN
  logic [OUTPUT_WIDTH-1:0] exp_mem [NUMBER_OF_TESTS];
  logic [ADDR_WIDTH:0]     mismatch_q;

  // Expected-response store, written alongside the vector store.
  always_ff @(posedge clk) begin
    if (mem_we) exp_mem[bus.load_addr] <= bus.exp_data;
  end

  // Count accepted results that differ from their expected response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= '0;
    end else if ((state == IDLE) && bus.start) begin
      mismatch_q <= '0;
    end else if (handshake && (res_data_q != exp_mem[res_index_q])) begin
      mismatch_q <= mismatch_q + 1'b1;
    end
  end

  assign bus.mismatch_cnt = mismatch_q;
`endif
endmodule

// File: tb/tb_test_vector_sequencer.sv
// Bench for test_vector_sequencer with a 2-input AND gate as the DUT and
// SETTLE_CYCLES=3. Compiles with or without SEQ_COMPARE_EN.
module tb_test_vector_sequencer;
  localparam int IW = 2;
  localparam int OW = 1;
  localparam int NT = 4;
  localparam int SC = 3;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  test_vector_sequencer_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .NUMBER_OF_TESTS(NT)) bus ();

  test_vector_sequencer #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .NUMBER_OF_TESTS(NT), .SETTLE_CYCLES(SC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Device under test hanging off the sequencer: a 2-input AND gate.
  assign bus.dut_out = &bus.dut_in;

  logic [OW-1:0] exp_drive;
`ifdef SEQ_COMPARE_EN
  assign bus.exp_data = exp_drive;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural reference model + per-cycle compare -------
  typedef struct {int idx; int vin; int data;} res_t;
  res_t log_q[$];
  int   vcyc  [NT];          // cycles res_valid was seen per index
  int   gap_a [NT];          // edges from last dut_in change to res_valid rise
  int   done_cnt = 0;

  logic [IW-1:0] mem_m  [NT];
  logic [OW-1:0] expm_m [NT];
  bit   running, done_exp, valid_exp, fresh;
  int   idx, apply_edge, mism, edge_n, chg_edge;
  logic [IW-1:0] exp_in;

  bit   p_start, p_load, p_ready, p_valid, prev_valid;
  logic [AW-1:0] p_addr;
  logic [IW-1:0] p_data, p_in, prev_in;
  logic [OW-1:0] p_exp, p_rdata;
  int   p_ridx;

  bit rst_at_edge = 1'b0;
  bit rst_seen    = 1'b0;
  always @(posedge clk) rst_at_edge = rst_n;
  always @(negedge rst_n) rst_seen = 1'b1;

  always @(negedge clk) begin
    bit was_done;
    logic [OW-1:0] exp_res;
    if (!rst_at_edge || rst_seen) begin
      rst_seen = 1'b0;
      running = 0; done_exp = 0; valid_exp = 0; fresh = 1;
      idx = 0; mism = 0; exp_in = '0;
      check("rst_busy",      bus.busy,      0);
      check("rst_done",      bus.done,      0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_dut_in",    bus.dut_in,    0);
      check("rst_res_index", bus.res_index, 0);
      check("rst_res_data",  bus.res_data,  0);
`ifdef SEQ_COMPARE_EN
      check("rst_mismatch",  bus.mismatch_cnt, 0);
`endif
    end else begin
      edge_n++;
      was_done = done_exp;
      done_exp = 0;
      if (!running && !was_done) begin
        if (p_start) begin
          running = 1; fresh = 0; idx = 0; apply_edge = edge_n;
          exp_in = mem_m[0]; mism = 0;
        end else if (p_load) begin
          mem_m[p_addr]  = p_data;
          expm_m[p_addr] = p_exp;
        end
      end else if (running && p_valid && p_ready) begin
        log_q.push_back('{p_ridx, int'(p_in), int'(p_rdata)});
        if ((&mem_m[idx]) != expm_m[idx]) mism++;
        if (idx == NT - 1) begin
          running = 0; done_exp = 1;
        end else begin
          idx++; apply_edge = edge_n; exp_in = mem_m[idx];
        end
      end
      valid_exp = running && (edge_n >= apply_edge + SC);
      exp_res   = &mem_m[idx];
      if (bus.dut_in !== prev_in) chg_edge = edge_n;
      if (bus.res_valid === 1'b1 && !prev_valid) gap_a[bus.res_index] = edge_n - chg_edge;
      if (bus.res_valid === 1'b1) vcyc[bus.res_index]++;
      if (bus.done === 1'b1) done_cnt++;

      check("busy",      bus.busy,      running);
      check("done",      bus.done,      done_exp);
      check("res_valid", bus.res_valid, valid_exp);
      check("dut_in",    bus.dut_in,    exp_in);
      if (valid_exp) begin
        check("res_index", bus.res_index, idx);
        check("res_data",  bus.res_data,  exp_res);
      end
      if (fresh) begin
        check("idle_res_index", bus.res_index, 0);
        check("idle_res_data",  bus.res_data,  0);
      end
`ifdef SEQ_COMPARE_EN
      check("mismatch_cnt", bus.mismatch_cnt, mism);
`endif
    end
    p_start = bus.start;   p_load = bus.load_en;  p_ready = bus.res_ready;
    p_addr  = bus.load_addr; p_data = bus.load_data; p_exp = exp_drive;
    p_valid = valid_exp;   p_ridx = int'(bus.res_index);
    p_in    = bus.dut_in;  p_rdata = bus.res_data;
    prev_in = bus.dut_in;  prev_valid = (bus.res_valid === 1'b1);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [IW-1:0] d, input logic [OW-1:0] e);
    bus.load_en = 1'b1; bus.load_addr = AW'(a); bus.load_data = d; exp_drive = e;
    step();
    bus.load_en = 1'b0;
  endtask

  task automatic clear_stats();
    log_q.delete();
    for (int i = 0; i < NT; i++) begin vcyc[i] = 0; gap_a[i] = 0; end
  endtask

  // mode 0: ready=1; 1: random ready + random start/load noise;
  // 2: hold ready low 5 cycles on index 1; 3: start/load(0,11) noise, ready=1
  task automatic run(input int mode, input bit collide);
    int  stall = 0;
    bit  fin   = 0;
    int  d0    = done_cnt;
    clear_stats();
    bus.start = 1'b1;
    bus.res_ready = 1'b1;
    if (collide) begin
      bus.load_en = 1'b1; bus.load_addr = '0; bus.load_data = 2'b11;
    end
    step();
    bus.start = 1'b0; bus.load_en = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      case (mode)
        1: begin
          bus.res_ready = ($urandom_range(0, 3) != 0);
          bus.start     = ($urandom_range(0, 7) == 0);
          bus.load_en   = $urandom_range(0, 1);
          bus.load_addr = AW'($urandom_range(0, NT - 1));
          bus.load_data = IW'($urandom);
          exp_drive     = OW'($urandom);
        end
        2: begin
          if (bus.res_valid && bus.res_index == 1 && stall < 5) begin
            bus.res_ready = 1'b0; stall++;
          end else begin
            bus.res_ready = 1'b1;
          end
        end
        3: begin
          bus.res_ready = 1'b1;
          bus.start     = $urandom_range(0, 1);
          bus.load_en   = 1'b1; bus.load_addr = '0; bus.load_data = 2'b11;
        end
        default: bus.res_ready = 1'b1;
      endcase
      step();
      if (bus.done) fin = 1;
    end
    check("run_completes", fin, 1);
    if (mode == 1) begin
      bus.start = $urandom_range(0, 1);  // lands in the done cycle
      bus.load_en = 1'b0;
    end else begin
      bus.start = 1'b0; bus.load_en = 1'b0;
    end
    bus.res_ready = 1'b0;
    step();
    bus.start = 1'b0; bus.load_en = 1'b0;
    check("one_done_pulse", done_cnt - d0, 1);
    check("busy_after_run", bus.busy, 0);
    check("results_per_run", log_q.size(), NT);
  endtask

  // Results expected for vectors 00,01,10,11 through an AND gate.
  task automatic check_std_log(input string tag);
    if (log_q.size() == NT) begin
      for (int i = 0; i < NT; i++) begin
        check({tag, "_idx"},  log_q[i].idx,  i);
        check({tag, "_vin"},  log_q[i].vin,  i);
        check({tag, "_data"}, log_q[i].data, (i == 3) ? 1 : 0);
      end
    end
  endtask

  initial begin
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.start = 1'b0; bus.res_ready = 1'b0; exp_drive = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Basic AND sweep, expected responses all 0.
    for (int i = 0; i < NT; i++) load(i, IW'(i), '0);
    run(0, 0);
    check_std_log("and_sweep");
    check("valid_cycles_idx0", vcyc[0], 1);
    for (int i = 1; i < NT; i++) check("settle_gap", gap_a[i], SC);
`ifdef SEQ_COMPARE_EN
    check("mismatch_at_done", bus.mismatch_cnt, 1);
`endif

    // Consumer back-pressure on index 1.
    run(2, 0);
    check_std_log("stall");
    check("stall_valid_cycles_idx1", vcyc[1], 6);
    check("stall_valid_cycles_idx2", vcyc[2], 1);

    // start/load noise during a run, then start colliding with a write.
    run(3, 0);
    check_std_log("noise");
    run(0, 1);
    check_std_log("collide");
    check("mem0_kept", log_q.size() > 0 ? log_q[0].vin : -1, 0);

    // Reset in the settle phase of index 2.
    clear_stats();
    bus.start = 1'b1; bus.res_ready = 1'b1;
    step();
    bus.start = 1'b0;
    begin
      bit hit = 0;
      for (int c = 0; c < 100 && !hit; c++) begin
        step();
        if (bus.busy && !bus.res_valid && bus.dut_in == 2'b10) hit = 1;
      end
      check("reached_settle_idx2", hit, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy",      bus.busy,      0);
    check("async_rst_res_valid", bus.res_valid, 0);
    check("async_rst_dut_in",    bus.dut_in,    0);
    check("async_rst_res_index", bus.res_index, 0);
    check("async_rst_res_data",  bus.res_data,  0);
    check("async_rst_done",      bus.done,      0);
    bus.res_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    run(0, 0);
    check_std_log("after_reset");

    // Randomized contents, back-pressure and noise.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NT; i++)
        if (r == 0 || $urandom_range(0, 2) != 0) load(i, IW'($urandom), OW'($urandom));
      if ($urandom_range(0, 1)) step();
      run(1, $urandom_range(0, 1));
    end

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/test_vector_sequencer.md
TEST_VECTOR_SEQUENCER -- requirements
Module: test_vector_sequencer

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 2, width of one stimulus vector.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 1, width of one DUT response.
REQ-003 SHALL have parameter NUMBER_OF_TESTS, default 4, vector memory depth (>=1).
REQ-004 SHALL have parameter SETTLE_CYCLES, default 1, cycles between applying a vector and sampling the response (>=1).
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port load_en, input, 1, write strobe for vector memory.
REQ-009 SHALL have port load_addr, input, clog2(NUMBER_OF_TESTS) (min 1), write address.
REQ-010 SHALL have port load_data, input, INPUT_WIDTH, stimulus vector to store.
REQ-011 SHALL have port start, input, 1, begin a run.
REQ-012 SHALL have port busy, output, 1, high from the run's first cycle until done.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at end of run.
REQ-014 SHALL have port dut_in, output, INPUT_WIDTH, registered stimulus to DUT.
REQ-015 SHALL have port dut_out, input, OUTPUT_WIDTH, DUT response.
REQ-016 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_index (output, load_addr width) and res_data (output, OUTPUT_WIDTH), forming the result valid/ready stream.

Function
REQ-017 SHALL use states IDLE, SETTLE, RESULT and DONE.
REQ-018 In IDLE, load_en SHALL write load_data to mem[load_addr] at the clock edge; load_en outside IDLE SHALL be ignored.
REQ-019 In IDLE with start=1, the next edge SHALL set index=0, dut_in=mem[0], busy=1 and enter SETTLE; start=1 with load_en=1 SHALL start the run and drop the write.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles; its last edge SHALL register res_data=dut_out, set res_index=index and res_valid=1, and enter RESULT.
REQ-021 In RESULT, res_valid, res_index and res_data SHALL stay stable until res_valid&&res_ready at an edge.
REQ-022 On that handshake, if index<NUMBER_OF_TESTS-1: index+1, dut_in=mem[index+1], res_valid=0, enter SETTLE.
REQ-023 On the handshake with index=NUMBER_OF_TESTS-1: res_valid=0, done=1, busy=0, enter DONE; DONE SHALL return to IDLE after one cycle with done=0.
REQ-024 start SHALL be ignored outside IDLE; dut_in SHALL hold the last applied vector after a run.
REQ-025 The index SHALL never wrap; each run SHALL emit exactly NUMBER_OF_TESTS results in index order.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, index=0, dut_in=0, res_valid=0, res_index=0, res_data=0, busy=0 and done=0, including mid-run.
REQ-027 Vector memory contents SHALL be retained across reset; no result SHALL be emitted from an aborted run.

Configuration
REQ-028 With macro SEQ_COMPARE_EN defined, the block SHALL add input exp_data (OUTPUT_WIDTH), written to exp_mem[load_addr] alongside load_data.
REQ-029 With SEQ_COMPARE_EN defined, it SHALL add output mismatch_cnt (load_addr width + 1), cleared at run start and on reset.
REQ-030 With SEQ_COMPARE_EN defined, mismatch_cnt SHALL increment on each handshake where res_data!=exp_mem[res_index].
REQ-031 Without SEQ_COMPARE_EN, exp_data, exp_mem and mismatch_cnt SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-032 Load 00,01,10,11; 2-input AND DUT; res_ready=1; start -> results (0,0),(1,0),(2,0),(3,1); one done pulse; busy low afterwards.
REQ-033 res_ready=0 for 5 cycles on index 1 -> res_valid held with res_data and res_index stable; index 2 not applied until the handshake.
REQ-034 SETTLE_CYCLES=3 -> dut_in changes exactly 3 edges before each res_valid rise.
REQ-035 start pulsed and load_en/load_addr=0/load_data=11 asserted mid-run -> run unaffected; mem[0] still 00.
REQ-036 rst_n low during SETTLE of index 2 -> all outputs 0 at once; a new start after release yields results from index 0 again.
REQ-037 SEQ_COMPARE_EN, expected 0,0,0,0 with AND DUT -> mismatch_cnt=1 at done.
